nonce_dispatch_arbiter: RTL and testbench
=========================================

Name: nonce_dispatch_arbiter

Overview:
- Sits between the top-level mining controller and NUM_CORES parallel SHA-256d hash cores.
- During the controller's solve phase it hands out unique 32-bit nonces to ready cores, round-robin.
- It arbitrates simultaneous solution claims from cores into the single sol_claim/sol_response handshake toward the controller.
- On a new job (restart) it clears all progress.

Parameters:
- NUM_CORES, 4, number of hash cores served (2..16).
- IDX_W, 2, width of a core index, equal to clog2(NUM_CORES).

Ports:
- clk  in  1  clock.
- n_rst  in  1  asynchronous, active-low reset.
- restart  in  1  one-cycle pulse on new job; clears nonce space and claim state.
- solve_en  in  1  high while the controller is in SOLVE; enables dispatch.
- core_ready  in  NUM_CORES  per-core request for the next nonce (level).
- nonce_grant  out  NUM_CORES  one-hot, one-cycle pulse; the addressed core takes nonce_out.
- nonce_out  out  32  nonce accompanying nonce_grant.
- core_found  in  NUM_CORES  per-core solution flag; held until found_ack.
- core_found_nonce  in  32*NUM_CORES  the winning nonce of core i is in bits [32i+31:32i].
- found_ack  out  NUM_CORES  one-hot, one-cycle pulse when a core's claim is latched.
- sol_claim  out  1  a solution is pending controller verification.
- sol_nonce  out  32  latched claimed nonce.
- sol_core  out  IDX_W  index of the claiming core.
- sol_response  in  2  00 pending, 01 rejected (resume), 10/11 accepted (job done).
- exhausted  out  1  all 2^32 nonces have been dispatched.
- job_done  out  1  an accepted solution was reported for the current job.

Behaviour:
- Reset: all outputs 0, nonce counter 0, both RR pointers 0, FSM in IDLE.
- FSM states:
  - IDLE: waiting for solve_en.
  - DISPATCH: granting nonces.
  - CLAIM: sol_claim high, awaiting the controller's response.
  - DONE: job finished (accepted solution or exhausted).
- Transitions, evaluated in this priority order:
  1. restart (any state) -> IDLE. Clears counter, exhausted, job_done, sol_claim and RR pointers. Outputs are 0 the next cycle. restart overrides every other event in the same cycle.
  2. Any core_found high and no claim latched -> CLAIM. This holds from IDLE or DISPATCH regardless of solve_en.
  3. IDLE with solve_en high -> DISPATCH.
  4. DISPATCH with solve_en low -> IDLE.
- Dispatch, DISPATCH state only, solve_en=1, exhausted=0:
  - Each cycle, pick one requesting core by round-robin, starting the search at ptr_d.
  - The core granted in the previous cycle is masked from the search.
  - Registered outputs: nonce_grant[i] and nonce_out=counter appear the next cycle. Latency from core_ready to grant is 1 cycle.
  - Then counter increments and ptr_d becomes i+1 (mod NUM_CORES).
  - Granting counter value 0xFFFFFFFF sets exhausted=1 and moves the FSM to DONE. The counter wraps to 0, but no further grants are issued.
- Claim arbitration:
  - Search core_found round-robin from ptr_c; take winner i.
  - Latch sol_nonce=core_found_nonce[i] and sol_core=i.
  - Next cycle: sol_claim=1 and found_ack[i]=1, for one cycle only. ptr_c becomes i+1.
  - In CLAIM no grants are issued. Other cores' core_found requests wait; they are not acked.
- If core_found and a dispatch candidate occur in the same cycle, the claim wins and no grant is issued that cycle.
- CLAIM exit:
  - sol_response=00: hold. sol_claim, sol_nonce and sol_core stay stable.
  - sol_response=01: sol_claim drops the next cycle. Go to DISPATCH if solve_en else IDLE. A pending core_found is serviced before any dispatch resumes.
  - sol_response=10 or 11: sol_claim drops, job_done=1, go to DONE.
- DONE: no grants and no new claims are latched; core_found is left un-acked. Only restart exits.
- sol_response is ignored outside CLAIM.
- Reset asserted mid-claim or mid-dispatch clears everything asynchronously. No partial grant pulse may remain.

Test Plan:
- Reset, then restart, then solve_en=1 with all 4 core_ready held high -> grants 0001,0010,0100,1000,0001 on consecutive cycles, with nonce_out 0,1,2,3,4.
- Only core 2 ready, held high -> grants to core 2 every other cycle (back-to-back masking), nonces incrementing by 1 per grant.
- Cores 1 and 3 raise core_found together with nonces 0x0000ABCD and 0x12345678 -> core 1 is acked first (sol_nonce=0x0000ABCD). Respond 01 -> core 3 is then acked with sol_nonce=0x12345678, and no grant is issued in between.
- While in CLAIM, hold sol_response=00 for 10 cycles and keep core_ready high -> no nonce_grant, and sol_claim stays stable. Then respond 10 -> job_done=1, and grants stop permanently until restart.
- Force the counter to 0xFFFFFFFE (via back-door or a long run) -> two grants (…FE, …FF), then exhausted=1, FSM in DONE, no further grants.
- Assert restart in the same cycle as core_found and a grant candidate -> no ack, no grant. The next cycle shows counter 0, sol_claim 0 and exhausted 0.

Source files
------------

// File: rtl/nonce_dispatch_arbiter_if.sv
// Controller/core-side bundle of the nonce dispatch arbiter: grant, claim and status signals.
// slave is the arbiter's view; master is the view of whoever drives the cores and the controller.
interface nonce_dispatch_arbiter_if #(
  parameter int NUM_CORES = 4,
  parameter int IDX_W     = 2
);
  logic                    restart;
  logic                    solve_en;
  logic [NUM_CORES-1:0]    core_ready;
  logic [NUM_CORES-1:0]    nonce_grant;
  logic [31:0]             nonce_out;
  logic [NUM_CORES-1:0]    core_found;
  logic [32*NUM_CORES-1:0] core_found_nonce;
  logic [NUM_CORES-1:0]    found_ack;
  logic                    sol_claim;
  logic [31:0]             sol_nonce;
  logic [IDX_W-1:0]        sol_core;
  logic [1:0]              sol_response;
  logic                    exhausted;
  logic                    job_done;

  modport master (
    output restart, solve_en, core_ready, core_found, core_found_nonce, sol_response,
    input  nonce_grant, nonce_out, found_ack, sol_claim, sol_nonce, sol_core, exhausted, job_done
  );

  modport slave (
    input  restart, solve_en, core_ready, core_found, core_found_nonce, sol_response,
    output nonce_grant, nonce_out, found_ack, sol_claim, sol_nonce, sol_core, exhausted, job_done
  );
endinterface

// File: rtl/nonce_dispatch_arbiter.sv
// Hands out unique 32-bit nonces round-robin to ready hash cores and funnels their
// solution claims, one at a time, into the controller's claim/response handshake.
module nonce_dispatch_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int IDX_W     = 2
) (
  input  logic                   clk,
  input  logic                   n_rst,
  nonce_dispatch_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DISPATCH = 2'd1;
  localparam logic [1:0] ST_CLAIM    = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;

  localparam logic [31:0]          NONCE_LAST = 32'hFFFF_FFFF;
  localparam logic [NUM_CORES-1:0] ONE_HOT0   = NUM_CORES'(1);

  logic [1:0]           state;
  logic [31:0]          nonce_cnt;
  logic [IDX_W-1:0]     ptr_d;
  logic [IDX_W-1:0]     ptr_c;
  logic [NUM_CORES-1:0] grant_q;
  logic [NUM_CORES-1:0] ack_q;
  logic [31:0]          nonce_q;
  logic                 sol_claim_q;
  logic [31:0]          sol_nonce_q;
  logic [IDX_W-1:0]     sol_core_q;
  logic                 exhausted_q;
  logic                 job_done_q;

  logic [31:0]          found_nonce [NUM_CORES];
  logic [IDX_W:0]       claim_pick;
  logic [IDX_W:0]       disp_pick;
  logic                 claim_go;
  logic                 disp_go;

  // Returns {found, index} of the first set request at or after ptr, wrapping.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_CORES-1:0] req,
                                             input logic [IDX_W-1:0]     ptr);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] sel;
    res = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      sel = IDX_W'((int'(ptr) + k) % NUM_CORES);
      if (req[sel]) res = {1'b1, sel};
    end
    return res;
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (int'(i) == NUM_CORES - 1) ? '0 : i + 1'b1;
  endfunction

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_found_nonce
    assign found_nonce[g] = bus.core_found_nonce[32*g +: 32];
  end

  // The core granted last cycle is masked so a core holding ready high cannot take two in a row.
  always_comb begin
    claim_pick = rr_pick(bus.core_found, ptr_c);
    disp_pick  = rr_pick(bus.core_ready & ~grant_q, ptr_d);
    claim_go   = claim_pick[IDX_W] && (state == ST_IDLE || state == ST_DISPATCH);
    disp_go    = disp_pick[IDX_W] && (state == ST_DISPATCH) && bus.solve_en &&
                 !exhausted_q && !claim_go;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= ST_IDLE;      nonce_cnt   <= '0; ptr_d      <= '0; ptr_c       <= '0;
      grant_q <= '0;         ack_q       <= '0; nonce_q    <= '0; sol_claim_q <= 1'b0;
      sol_nonce_q <= '0;     sol_core_q  <= '0; exhausted_q <= 1'b0; job_done_q <= 1'b0;
    end else if (bus.restart) begin
      state <= ST_IDLE;      nonce_cnt   <= '0; ptr_d      <= '0; ptr_c       <= '0;
      grant_q <= '0;         ack_q       <= '0; nonce_q    <= '0; sol_claim_q <= 1'b0;
      sol_nonce_q <= '0;     sol_core_q  <= '0; exhausted_q <= 1'b0; job_done_q <= 1'b0;
    end else begin
      grant_q <= '0;
      ack_q   <= '0;
      if (claim_go) begin
        state       <= ST_CLAIM;
        sol_claim_q <= 1'b1;
        ack_q       <= ONE_HOT0 << claim_pick[IDX_W-1:0];
        sol_nonce_q <= found_nonce[claim_pick[IDX_W-1:0]];
        sol_core_q  <= claim_pick[IDX_W-1:0];
        ptr_c       <= next_idx(claim_pick[IDX_W-1:0]);
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.solve_en) state <= ST_DISPATCH;
          end
          ST_DISPATCH: begin
            if (!bus.solve_en) begin
              state <= ST_IDLE;
            end else if (disp_go) begin
              grant_q   <= ONE_HOT0 << disp_pick[IDX_W-1:0];
              nonce_q   <= nonce_cnt;
              nonce_cnt <= nonce_cnt + 32'd1;
              ptr_d     <= next_idx(disp_pick[IDX_W-1:0]);
              // Handing out the last nonce ends the job; the counter wraps but stays unused.
              if (nonce_cnt == NONCE_LAST) begin
                exhausted_q <= 1'b1;
                state       <= ST_DONE;
              end
            end
          end
          ST_CLAIM: begin
            case (bus.sol_response)
              2'b00: ;
              2'b01: begin
                sol_claim_q <= 1'b0;
                state       <= bus.solve_en ? ST_DISPATCH : ST_IDLE;
              end
              default: begin
                sol_claim_q <= 1'b0;
                job_done_q  <= 1'b1;
                state       <= ST_DONE;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.nonce_grant = grant_q;
  assign bus.nonce_out   = nonce_q;
  assign bus.found_ack   = ack_q;
  assign bus.sol_claim   = sol_claim_q;
  assign bus.sol_nonce   = sol_nonce_q;
  assign bus.sol_core    = sol_core_q;
  assign bus.exhausted   = exhausted_q;
  assign bus.job_done    = job_done_q;

endmodule

// File: tb/tb_nonce_dispatch_arbiter.sv
// Scoreboard bench for nonce_dispatch_arbiter: expected grants/claims are queued as
// stimulus is applied and popped as the arbiter produces them.
module tb_nonce_dispatch_arbiter;

  logic clk;
  logic n_rst;

  nonce_dispatch_arbiter_if #(.NUM_CORES(4), .IDX_W(2)) bus ();

  nonce_dispatch_arbiter #(.NUM_CORES(4), .IDX_W(2)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  onehot;
    logic [31:0] nonce;
    logic [1:0]  core;
  } exp_t;

  exp_t grant_q[$];
  exp_t claim_q[$];
  int   tests;
  int   fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_restart();
    @(negedge clk);
    bus.restart = 1'b1;
    @(negedge clk);
    bus.restart = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    bus.restart = 1'b0; bus.solve_en = 1'b0; bus.core_ready = '0;
    bus.core_found = '0; bus.core_found_nonce = '0; bus.sol_response = 2'b00;
    repeat (3) tick();
    tests++; if (bus.nonce_grant !== 4'b0) begin fails++; $display("FAIL reset_grant got %b want 0000", bus.nonce_grant); end
    tests++; if (bus.nonce_out !== 32'h0) begin fails++; $display("FAIL reset_nonce_out got %h want 0", bus.nonce_out); end
    tests++; if (bus.found_ack !== 4'b0) begin fails++; $display("FAIL reset_ack got %b want 0000", bus.found_ack); end
    tests++; if (bus.sol_claim !== 1'b0) begin fails++; $display("FAIL reset_sol_claim got %b want 0", bus.sol_claim); end
    tests++; if (bus.sol_nonce !== 32'h0) begin fails++; $display("FAIL reset_sol_nonce got %h want 0", bus.sol_nonce); end
    tests++; if (bus.sol_core !== 2'd0) begin fails++; $display("FAIL reset_sol_core got %0d want 0", bus.sol_core); end
    tests++; if (bus.exhausted !== 1'b0) begin fails++; $display("FAIL reset_exhausted got %b want 0", bus.exhausted); end
    tests++; if (bus.job_done !== 1'b0) begin fails++; $display("FAIL reset_job_done got %b want 0", bus.job_done); end
    tests++; if (dut.state !== 2'd0) begin fails++; $display("FAIL reset_state got %0d want 0", dut.state); end
    n_rst = 1'b1;
  endtask

  task automatic test_round_robin();
    int first_cyc;
    int last_cyc;
    exp_t e;
    do_restart();
    for (int i = 0; i < 5; i++) grant_q.push_back('{onehot: 4'b0001 << (i % 4), nonce: i, core: 2'(i % 4)});
    bus.solve_en = 1'b1;
    bus.core_ready = 4'b1111;
    first_cyc = -1; last_cyc = -1;
    for (int cyc = 0; cyc < 20 && grant_q.size() != 0; cyc++) begin
      tick();
      if (bus.nonce_grant != 4'b0) begin
        e = grant_q.pop_front();
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        tests++; if (bus.nonce_grant !== e.onehot) begin fails++; $display("FAIL rr_grant got %b want %b", bus.nonce_grant, e.onehot); end
        tests++; if (bus.nonce_out !== e.nonce) begin fails++; $display("FAIL rr_nonce got %h want %h", bus.nonce_out, e.nonce); end
      end
    end
    bus.core_ready = 4'b0;
    tests++; if (grant_q.size() != 0) begin fails++; $display("FAIL rr_timeout got %0d pending want 0", grant_q.size()); end
    tests++; if (last_cyc - first_cyc != 4) begin fails++; $display("FAIL rr_consecutive got span %0d want 4", last_cyc - first_cyc); end
    grant_q.delete();
  endtask

  task automatic test_single_core_masking();
    int prev_cyc;
    exp_t e;
    for (int i = 0; i < 4; i++) grant_q.push_back('{onehot: 4'b0100, nonce: 32'd5 + i, core: 2'd2});
    bus.core_ready = 4'b0100;
    prev_cyc = -1;
    for (int cyc = 0; cyc < 20 && grant_q.size() != 0; cyc++) begin
      tick();
      if (bus.nonce_grant != 4'b0) begin
        e = grant_q.pop_front();
        tests++; if (bus.nonce_grant !== e.onehot) begin fails++; $display("FAIL mask_grant got %b want %b", bus.nonce_grant, e.onehot); end
        tests++; if (bus.nonce_out !== e.nonce) begin fails++; $display("FAIL mask_nonce got %h want %h", bus.nonce_out, e.nonce); end
        if (prev_cyc >= 0) begin
          tests++; if (cyc - prev_cyc != 2) begin fails++; $display("FAIL mask_gap got %0d want 2", cyc - prev_cyc); end
        end
        prev_cyc = cyc;
      end
    end
    bus.core_ready = 4'b0;
    tests++; if (grant_q.size() != 0) begin fails++; $display("FAIL mask_timeout got %0d pending want 0", grant_q.size()); end
    grant_q.delete();
  endtask

  task automatic test_claim_arbitration();
    exp_t e;
    logic got;
    claim_q.push_back('{onehot: 4'b0010, nonce: 32'h0000_ABCD, core: 2'd1});
    claim_q.push_back('{onehot: 4'b1000, nonce: 32'h1234_5678, core: 2'd3});
    bus.core_found_nonce[32*1 +: 32] = 32'h0000_ABCD;
    bus.core_found_nonce[32*3 +: 32] = 32'h1234_5678;
    bus.core_found = 4'b1010;
    bus.core_ready = 4'b1111;
    for (int k = 0; k < 2; k++) begin
      got = 1'b0;
      for (int cyc = 0; cyc < 10 && !got; cyc++) begin
        tick();
        tests++; if (bus.nonce_grant !== 4'b0) begin fails++; $display("FAIL claim_no_grant got %b want 0000", bus.nonce_grant); end
        if (bus.found_ack != 4'b0) got = 1'b1;
      end
      tests++;
      if (!got) begin
        fails++; $display("FAIL claim_ack_timeout got no ack want ack %0d", k);
      end else begin
        e = claim_q.pop_front();
        if (bus.found_ack !== e.onehot) begin fails++; $display("FAIL claim_ack got %b want %b", bus.found_ack, e.onehot); end
        tests++; if (bus.sol_nonce !== e.nonce) begin fails++; $display("FAIL claim_nonce got %h want %h", bus.sol_nonce, e.nonce); end
        tests++; if (bus.sol_core !== e.core) begin fails++; $display("FAIL claim_core got %0d want %0d", bus.sol_core, e.core); end
        tests++; if (bus.sol_claim !== 1'b1) begin fails++; $display("FAIL claim_flag got %b want 1", bus.sol_claim); end
        bus.core_found[e.core] = 1'b0;
      end
      if (k == 0) begin
        bus.sol_response = 2'b01;
        tick();
        bus.sol_response = 2'b00;
        tests++; if (bus.sol_claim !== 1'b0) begin fails++; $display("FAIL reject_drop got %b want 0", bus.sol_claim); end
        tests++; if (bus.nonce_grant !== 4'b0) begin fails++; $display("FAIL reject_no_grant got %b want 0000", bus.nonce_grant); end
        tests++; if (bus.found_ack !== 4'b0) begin fails++; $display("FAIL reject_no_ack got %b want 0000", bus.found_ack); end
      end
    end
    bus.core_found = 4'b0;
    claim_q.delete();
  endtask

  task automatic test_claim_hold_accept();
    for (int cyc = 0; cyc < 10; cyc++) begin
      tick();
      tests++; if (bus.nonce_grant !== 4'b0) begin fails++; $display("FAIL hold_grant got %b want 0000", bus.nonce_grant); end
      tests++; if (bus.sol_claim !== 1'b1) begin fails++; $display("FAIL hold_claim got %b want 1", bus.sol_claim); end
      tests++; if (bus.sol_nonce !== 32'h1234_5678) begin fails++; $display("FAIL hold_nonce got %h want 12345678", bus.sol_nonce); end
      tests++; if (bus.sol_core !== 2'd3) begin fails++; $display("FAIL hold_core got %0d want 3", bus.sol_core); end
      tests++; if (bus.found_ack !== 4'b0) begin fails++; $display("FAIL hold_ack got %b want 0000", bus.found_ack); end
    end
    bus.sol_response = 2'b10;
    tick();
    bus.sol_response = 2'b00;
    tests++; if (bus.sol_claim !== 1'b0) begin fails++; $display("FAIL accept_drop got %b want 0", bus.sol_claim); end
    tests++; if (bus.job_done !== 1'b1) begin fails++; $display("FAIL accept_job_done got %b want 1", bus.job_done); end
    bus.core_found_nonce[32*0 +: 32] = 32'hDEAD_BEEF;
    bus.core_found = 4'b0001;
    for (int cyc = 0; cyc < 8; cyc++) begin
      tick();
      tests++; if (bus.nonce_grant !== 4'b0) begin fails++; $display("FAIL done_grant got %b want 0000", bus.nonce_grant); end
      tests++; if (bus.found_ack !== 4'b0) begin fails++; $display("FAIL done_ack got %b want 0000", bus.found_ack); end
      tests++; if (bus.job_done !== 1'b1) begin fails++; $display("FAIL done_job_done got %b want 1", bus.job_done); end
    end
    bus.core_found = 4'b0;
    bus.core_ready = 4'b0;
  endtask

  task automatic test_exhaust();
    exp_t e;
    do_restart();
    tests++; if (bus.job_done !== 1'b0) begin fails++; $display("FAIL restart_job_done got %b want 0", bus.job_done); end
    dut.nonce_cnt = 32'hFFFF_FFFE;
    grant_q.push_back('{onehot: 4'b0001, nonce: 32'hFFFF_FFFE, core: 2'd0});
    grant_q.push_back('{onehot: 4'b0010, nonce: 32'hFFFF_FFFF, core: 2'd1});
    bus.solve_en = 1'b1;
    bus.core_ready = 4'b1111;
    for (int cyc = 0; cyc < 12; cyc++) begin
      tick();
      if (bus.nonce_grant != 4'b0) begin
        tests++;
        if (grant_q.size() == 0) begin
          fails++; $display("FAIL exhaust_extra_grant got %b want 0000", bus.nonce_grant);
        end else begin
          e = grant_q.pop_front();
          if (bus.nonce_grant !== e.onehot) begin fails++; $display("FAIL exhaust_grant got %b want %b", bus.nonce_grant, e.onehot); end
          tests++; if (bus.nonce_out !== e.nonce) begin fails++; $display("FAIL exhaust_nonce got %h want %h", bus.nonce_out, e.nonce); end
        end
      end
    end
    tests++; if (grant_q.size() != 0) begin fails++; $display("FAIL exhaust_pending got %0d want 0", grant_q.size()); end
    tests++; if (bus.exhausted !== 1'b1) begin fails++; $display("FAIL exhaust_flag got %b want 1", bus.exhausted); end
    tests++; if (dut.state !== 2'd3) begin fails++; $display("FAIL exhaust_state got %0d want 3", dut.state); end
    tests++; if (dut.nonce_cnt !== 32'h0) begin fails++; $display("FAIL exhaust_wrap got %h want 0", dut.nonce_cnt); end
    bus.core_ready = 4'b0;
    grant_q.delete();
  endtask

  task automatic test_restart_collision();
    do_restart();
    bus.solve_en = 1'b1;
    bus.core_ready = 4'b0001;
    repeat (5) tick();
    tests++; if (dut.nonce_cnt !== 32'd2) begin fails++; $display("FAIL collide_pre_cnt got %h want 2", dut.nonce_cnt); end
    bus.restart = 1'b1;
    bus.core_found_nonce[32*2 +: 32] = 32'h5555_AAAA;
    bus.core_found = 4'b0100;
    bus.core_ready = 4'b1111;
    tick();
    bus.restart = 1'b0;
    bus.core_found = 4'b0;
    bus.core_ready = 4'b0;
    bus.solve_en = 1'b0;
    tests++; if (bus.nonce_grant !== 4'b0) begin fails++; $display("FAIL collide_grant got %b want 0000", bus.nonce_grant); end
    tests++; if (bus.found_ack !== 4'b0) begin fails++; $display("FAIL collide_ack got %b want 0000", bus.found_ack); end
    tests++; if (bus.sol_claim !== 1'b0) begin fails++; $display("FAIL collide_claim got %b want 0", bus.sol_claim); end
    tests++; if (bus.exhausted !== 1'b0) begin fails++; $display("FAIL collide_exhausted got %b want 0", bus.exhausted); end
    tests++; if (dut.nonce_cnt !== 32'h0) begin fails++; $display("FAIL collide_cnt got %h want 0", dut.nonce_cnt); end
    tests++; if (bus.nonce_out !== 32'h0) begin fails++; $display("FAIL collide_nonce_out got %h want 0", bus.nonce_out); end
    tests++; if (dut.state !== 2'd0) begin fails++; $display("FAIL collide_state got %0d want 0", dut.state); end
  endtask

  task automatic test_async_reset();
    bus.solve_en = 1'b1;
    bus.core_ready = 4'b1111;
    @(posedge clk);
    @(posedge clk);
    #2;
    tests++; if (bus.nonce_grant !== 4'b0001) begin fails++; $display("FAIL areset_pre_grant got %b want 0001", bus.nonce_grant); end
    n_rst = 1'b0;
    #1;
    tests++; if (bus.nonce_grant !== 4'b0) begin fails++; $display("FAIL areset_grant got %b want 0000", bus.nonce_grant); end
    tests++; if (dut.nonce_cnt !== 32'h0) begin fails++; $display("FAIL areset_cnt got %h want 0", dut.nonce_cnt); end
    tests++; if (dut.state !== 2'd0) begin fails++; $display("FAIL areset_state got %0d want 0", dut.state); end
    tick();
    bus.solve_en = 1'b0;
    bus.core_ready = 4'b0;
    n_rst = 1'b1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_round_robin();
    test_single_core_masking();
    test_claim_arbitration();
    test_claim_hold_accept();
    test_exhaust();
    test_restart_collision();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
